xpar_mbox: RTL and testbench
============================

# xpar_mbox

Responder on picoVersat's external parallel interface (`par_addr`/`par_we`/`par_out`/`par_in`). It gives the processor a memory-mapped mailbox: an RX FIFO filled by a host-side streaming port and drained by software, and a TX FIFO filled by software and drained by the host. It sits outside `xtop` on the `EXT_BASE` bus, facing the processor on one side and a valid/ready host on the other.

## Interface
- `DATA_W`, 32, bus and FIFO word width (matches `DATA_W` in xdefs.vh)
- `PAR_ADDR_W`, 4, width of `par_addr` (`ADDR_W-1` at top level); only bits [1:0] are decoded
- `DEPTH_LOG2`, 3, log2 of each FIFO depth (default 8 words)

- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `par_addr` in PAR_ADDR_W register select from xtop
- `par_we` in 1 write strobe from xtop
- `par_out` in DATA_W write data from xtop
- `par_in` out DATA_W read data to xtop
- `host_rx_data` in DATA_W host word to RX FIFO
- `host_rx_valid` in 1 host offers word
- `host_rx_ready` out 1 RX FIFO not full
- `host_tx_data` out DATA_W TX FIFO head word
- `host_tx_valid` out 1 TX FIFO not empty
- `host_tx_ready` in 1 host accepts word
- `irq` out 1 interrupt, only with `MBOX_IRQ_EN`

Clock is `clk`; reset is `rst`, synchronous and active-high; single clock domain.

## Operation
- Register map, `par_addr[1:0]`:
  - 0 DATA: read = RX head (0 when empty), no side effect; write = push `par_out` to TX FIFO
  - 1 STATUS: read bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_ovf, bit5 rx_unf, bit6 irq_en, others 0; write: bit4/bit5 write-1-to-clear, bit6 loads irq_en
  - 2 POP: write (any data) pops RX head; read returns 0
  - 3 LEVEL: read {tx_level in [23:16], rx_level in [7:0]}, zero-extended; write ignored
- Reads have no side effects; popping is explicit via POP.
- TX push while full: word dropped, tx_ovf set. POP while RX empty: ignored, rx_unf set. Sticky until cleared or reset.
- Host RX push when `host_rx_valid & host_rx_ready`; TX pop when `host_tx_valid & host_tx_ready`.
- Simultaneous push and pop on the same FIFO (non-empty, non-full): both happen, level unchanged. When full, `host_rx_ready`=0 that cycle even if POP happens; push waits one cycle.
- Levels count 0..2^DEPTH_LOG2 (DEPTH_LOG2+1 bits); pointers wrap modulo depth.

## Timing
- `par_in` combinational from `par_addr` and registered state; zero-latency read, as xtop samples in the same cycle.
- Processor write takes effect at the posedge with `par_we`=1; visible on reads and `host_tx_valid` next cycle.
- Host push at posedge N: word on `par_in` (addr 0) and rx_empty=0 from cycle N+1.
- `host_rx_ready`, `host_tx_valid` are registered-state functions (!full, !empty), no comb path from valid/ready inputs.
- Reset: pointers, levels, flags, irq_en cleared; `host_rx_ready`=1, `host_tx_valid`=0, `par_in` at addr 1 reads 0x5 (both empty), `irq`=0. FIFO storage not cleared; reset mid-transfer discards contents.

## Configuration
- `MBOX_IRQ_EN` defined: `irq` port present, registered, `irq` = irq_en & (!rx_empty | tx_ovf), asserted cycle after condition arises.
- Undefined: no `irq` port, STATUS bit6 reads 0 and writes ignored.

## Structure
- `xmbox_defs.vh`: register address constants (`MBOX_DATA`, `MBOX_STATUS`, `MBOX_POP`, `MBOX_LEVEL`) and STATUS bit positions, shared with firmware headers.
- One sub-module `xsync_fifo` (parameterised width/depth, push/pop, full/empty/level, combinational head read), instantiated for RX and TX.

## Test plan
- Reset, read addr 1 -> 0x5; `host_rx_ready`=1, `host_tx_valid`=0, LEVEL=0.
- Host pushes 0xA, 0xB; read addr 0 -> 0xA; write POP; read addr 0 -> 0xB; LEVEL rx=1.
- Processor writes 0x11..0x18 to DATA (8), 9th write 0x99 -> tx_full, tx_ovf=1; host drains 0x11..0x18 in order, 0x99 absent; write STATUS 0x10 clears tx_ovf.
- RX full (8 words) with `host_rx_valid` held, POP same cycle -> push stalled one cycle, accepted next; level stays 8; order preserved.
- POP on empty RX -> rx_unf=1, level 0, `par_in` addr 0 = 0.
- With `MBOX_IRQ_EN`: write STATUS 0x40, host push -> `irq`=1 one cycle later; POP to empty -> `irq`=0 next cycle.

Source files
------------

// File: rtl/xpar_mbox_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xpar_mbox_pkg : register map and STATUS bit positions for the mailbox.
// Rev 1.0
// ----------------------------------------------------------------------------
package xpar_mbox_pkg;

  typedef enum logic [1:0] {
    MBOX_DATA   = 2'd0,
    MBOX_STATUS = 2'd1,
    MBOX_POP    = 2'd2,
    MBOX_LEVEL  = 2'd3
  } mbox_reg_e;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_IRQ_EN   = 6;

  localparam int LVL_TX_LSB  = 16;
  localparam int LVL_RX_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/xpar_mbox_xsync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xpar_mbox_xsync_fifo : synchronous FIFO, combinational head, level counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module xpar_mbox_xsync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  w_push, w_pop;

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = level_q[DEPTH_LOG2];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/xpar_mbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xpar_mbox : picoVersat parallel-bus mailbox with host RX/TX FIFOs.
// Define MBOX_IRQ_EN to add the registered irq output. Rev 1.0
// ----------------------------------------------------------------------------
module xpar_mbox
  import xpar_mbox_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAR_ADDR_W-1:0] par_addr,
  input  logic                  par_we,
  input  logic [DATA_W-1:0]     par_out,
  output logic [DATA_W-1:0]     par_in,
  input  logic [DATA_W-1:0]     host_rx_data,
  input  logic                  host_rx_valid,
  output logic                  host_rx_ready,
  output logic [DATA_W-1:0]     host_tx_data,
  output logic                  host_tx_valid,
  input  logic                  host_tx_ready
`ifdef MBOX_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int LVL_W = DEPTH_LOG2 + 1;

  mbox_reg_e         w_reg;
  logic              w_wr_data, w_wr_status, w_wr_pop;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [LVL_W-1:0]  rx_level, tx_level;
  logic              tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic              irq_en;
  logic [DATA_W-1:0] w_status, w_level;

  assign w_reg       = mbox_reg_e'(par_addr[1:0]);
  assign w_wr_data   = par_we & (w_reg == MBOX_DATA);
  assign w_wr_status = par_we & (w_reg == MBOX_STATUS);
  assign w_wr_pop    = par_we & (w_reg == MBOX_POP);

  generate
    if (PAR_ADDR_W > 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^par_addr[PAR_ADDR_W-1:2];
    end
  endgenerate

  // Ready excludes same-cycle POP so there is no comb path from par_we to the host.
  assign rx_push       = host_rx_valid & ~rx_full;
  assign rx_pop        = w_wr_pop & ~rx_empty;
  assign host_rx_ready = ~rx_full;

  assign tx_push       = w_wr_data & ~tx_full;
  assign tx_pop        = host_tx_ready & ~tx_empty;
  assign host_tx_valid = ~tx_empty;

  xpar_mbox_xsync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rx_push),
    .push_data_i (host_rx_data),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .level_o     (rx_level)
  );

  xpar_mbox_xsync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_push),
    .push_data_i (par_out),
    .pop_i       (tx_pop),
    .head_o      (host_tx_data),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .level_o     (tx_level)
  );

  assign tx_ovf_d = (tx_ovf_q & ~(w_wr_status & par_out[ST_TX_OVF])) | (w_wr_data & tx_full);
  assign rx_unf_d = (rx_unf_q & ~(w_wr_status & par_out[ST_RX_UNF])) | (w_wr_pop & rx_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

`ifdef MBOX_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (w_wr_status) irq_en_q <= par_out[ST_IRQ_EN];
      irq_q <= irq_en_q & (~rx_empty | tx_ovf_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    w_status              = '0;
    w_status[ST_RX_EMPTY] = rx_empty;
    w_status[ST_RX_FULL]  = rx_full;
    w_status[ST_TX_EMPTY] = tx_empty;
    w_status[ST_TX_FULL]  = tx_full;
    w_status[ST_TX_OVF]   = tx_ovf_q;
    w_status[ST_RX_UNF]   = rx_unf_q;
    w_status[ST_IRQ_EN]   = irq_en;
  end

  always_comb begin
    w_level                         = '0;
    w_level[LVL_TX_LSB +: LVL_W]    = tx_level;
    w_level[LVL_RX_LSB +: LVL_W]    = rx_level;
  end

  always_comb begin
    par_in = '0;
    case (w_reg)
      MBOX_DATA:   par_in = rx_empty ? '0 : rx_head;
      MBOX_STATUS: par_in = w_status;
      MBOX_LEVEL:  par_in = w_level;
      default:     par_in = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_xpar_mbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xpar_mbox : scoreboard bench for the parallel-bus mailbox.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_xpar_mbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  par_addr = '0;
  logic        par_we = 1'b0;
  logic [31:0] par_out = '0;
  logic [31:0] par_in;
  logic [31:0] host_rx_data = '0;
  logic        host_rx_valid = 1'b0;
  logic        host_rx_ready;
  logic [31:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready = 1'b0;
`ifdef MBOX_IRQ_EN
  logic        irq;
`endif

  xpar_mbox dut (
    .clk           (clk),
    .rst           (rst),
    .par_addr      (par_addr),
    .par_we        (par_we),
    .par_out       (par_out),
    .par_in        (par_in),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready)
`ifdef MBOX_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: kind 0 = par_in, 1 = {host_rx_ready, host_tx_valid}, 2 = irq
  logic [31:0] exp_q [$];
  int          kind_q [$];
  string       name_q [$];
  logic [31:0] tx_q [$];
  logic        chk_req = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    logic [31:0] e, act;
    int          k;
    string       nm;
    if (chk_req) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: check requested with no expected value");
      end else begin
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        act = '0;
        case (k)
          0: act = par_in;
          1: act = {30'b0, host_rx_ready, host_tx_valid};
`ifdef MBOX_IRQ_EN
          2: act = {31'b0, irq};
`endif
          default: act = 32'hDEAD_BEEF;
        endcase
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
        end
      end
    end
    if (host_tx_valid && host_tx_ready) begin
      n_checks++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected_word: got 0x%08h expected none", host_tx_data);
      end else begin
        e = tx_q.pop_front();
        if (host_tx_data !== e) begin
          n_err++;
          $display("FAIL tx_data: got 0x%08h expected 0x%08h", host_tx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    par_addr = {2'b00, a};
    par_out  = d;
    par_we   = 1'b1;
    tick();
    par_we   = 1'b0;
  endtask

  task automatic expect_read(input logic [1:0] a, input logic [31:0] e, input string nm);
    par_addr = {2'b00, a};
    exp_q.push_back(e);
    kind_q.push_back(0);
    name_q.push_back(nm);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic queue_check(input int k, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    kind_q.push_back(k);
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  task automatic host_push(input logic [31:0] d);
    host_rx_data  = d;
    host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    expect_read(2'd1, 32'h5, "reset_status");
    queue_check(1, 32'h2, "reset_handshake"); tick(); chk_req = 1'b0;
    expect_read(2'd3, 32'h0, "reset_level");
    expect_read(2'd0, 32'h0, "reset_data_empty");

    // Host RX push and explicit POP
    host_push(32'hA);
    host_push(32'hB);
    expect_read(2'd0, 32'hA, "rx_head_first");
    expect_read(2'd0, 32'hA, "rx_read_no_side_effect");
    cpu_write(2'd2, 32'h0);
    expect_read(2'd0, 32'hB, "rx_head_after_pop");
    expect_read(2'd3, 32'h1, "rx_level_one");
    expect_read(2'd1, 32'h4, "status_rx_nonempty");
    expect_read(2'd2, 32'h0, "pop_reads_zero");
    cpu_write(2'd2, 32'h0);

    // TX fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cpu_write(2'd0, 32'h11 + i);
      tx_q.push_back(32'h11 + i);
    end
    queue_check(1, 32'h3, "tx_valid_full"); tick(); chk_req = 1'b0;
    expect_read(2'd1, 32'h9, "status_tx_full");
    expect_read(2'd3, 32'h0008_0000, "tx_level_eight");
    cpu_write(2'd0, 32'h99);
    expect_read(2'd1, 32'h19, "status_tx_ovf");
    host_tx_ready = 1'b1;
    budget = 0;
    while (tx_q.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    host_tx_ready = 1'b0;
    if (budget >= 40) begin
      n_checks++;
      n_err++;
      $display("FAIL tx_drain_timeout: got %0d words left expected 0", tx_q.size());
    end
    expect_read(2'd1, 32'h15, "status_after_drain");
    cpu_write(2'd1, 32'h10);
    expect_read(2'd1, 32'h5, "status_ovf_cleared");

    // RX full with push and POP colliding
    for (int i = 0; i < 8; i++) host_push(32'h21 + i);
    queue_check(1, 32'h0, "rx_ready_low_full"); tick(); chk_req = 1'b0;
    expect_read(2'd1, 32'h6, "status_rx_full");
    expect_read(2'd3, 32'h8, "rx_level_eight");
    host_rx_data  = 32'h29;
    host_rx_valid = 1'b1;
    par_addr = 4'd2;
    par_out  = 32'h0;
    par_we   = 1'b1;
    queue_check(1, 32'h0, "rx_ready_low_during_pop");
    tick();
    par_we = 1'b0;
    queue_check(1, 32'h2, "rx_ready_after_pop");
    tick();
    chk_req = 1'b0;
    host_rx_valid = 1'b0;
    expect_read(2'd3, 32'h8, "rx_level_refilled");
    for (int i = 0; i < 8; i++) begin
      expect_read(2'd0, 32'h22 + i, "rx_order");
      cpu_write(2'd2, 32'h0);
    end
    expect_read(2'd1, 32'h5, "status_rx_drained");

    // POP on empty RX
    cpu_write(2'd2, 32'h0);
    expect_read(2'd1, 32'h25, "status_rx_unf");
    expect_read(2'd3, 32'h0, "level_after_unf");
    expect_read(2'd0, 32'h0, "data_after_unf");
    cpu_write(2'd1, 32'h20);
    expect_read(2'd1, 32'h5, "status_unf_cleared");

`ifdef MBOX_IRQ_EN
    cpu_write(2'd1, 32'h40);
    expect_read(2'd1, 32'h45, "status_irq_en");
    queue_check(2, 32'h0, "irq_idle"); tick(); chk_req = 1'b0;
    host_push(32'h77);
    tick();
    queue_check(2, 32'h1, "irq_asserted"); tick(); chk_req = 1'b0;
    cpu_write(2'd2, 32'h0);
    tick();
    queue_check(2, 32'h0, "irq_released"); tick(); chk_req = 1'b0;
`else
    cpu_write(2'd1, 32'h40);
    expect_read(2'd1, 32'h5, "status_irq_en_ignored");
`endif

    tick();
    n_checks++;
    if (exp_q.size() != 0 || tx_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d/%0d pending expected 0/0", exp_q.size(), tx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
